// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC sequencer and imem fetch controller with branch/jump/jr redirect and flush.
// Optional MISALIGN_TRAP_EN: a misaligned jr target sets sticky misalign and parks in TRAP.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr_out,
    output logic             instr_valid,
    output logic [31:0]      dec_pc4,
    input  logic             branch_en,
    input  logic             branch_cond,
    input  logic [IMM_W-1:0] branch_imm,
    input  logic             jump_en,
    input  logic [25:0]      jump_target,
    input  logic             jr_en,
    input  logic [31:0]      jr_addr,
    output logic             flush,
    output logic             misalign
);
`ifdef MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, TRAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
`endif
    state_t state, state_n;
    logic [31:0] pc, pc4, hold_buf, br_off, jr_tgt, target, word;
    logic redirect, deliver, trap;

    assign pc4      = pc + 32'd4;
    assign br_off   = {{(32-IMM_W){branch_imm[IMM_W-1]}}, branch_imm} << 2;
    // Redirects belong to the instruction currently held by decode, so they need a valid, unstalled word
    assign redirect = instr_valid & ~stall & (jr_en | jump_en | (branch_en & branch_cond));
    assign deliver  = ~redirect & ~stall & (((state == FETCH) & imem_ack) | (state == HOLD));
    assign word     = (state == HOLD) ? hold_buf : imem_rdata;
    assign target   = jr_en ? jr_tgt : jump_en ? {dec_pc4[31:28], jump_target, 2'b00} : dec_pc4 + br_off;

`ifdef MISALIGN_TRAP_EN
    assign jr_tgt = jr_addr;
    assign trap   = jr_en & (|jr_addr[1:0]);
    always_ff @(posedge clk)
        if (reset) misalign <= 1'b0;
        else if (redirect & trap) misalign <= 1'b1;
`else
    assign jr_tgt   = jr_addr & ~32'd3;
    assign trap     = 1'b0;
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else state <= state_n;

    always_comb begin
`ifdef MISALIGN_TRAP_EN
        state_n = (state == IDLE) ? FETCH :
                  redirect ? (trap ? TRAP : FETCH) :
                  ((state == FETCH) & imem_ack & stall) ? HOLD :
                  ((state == HOLD) & ~stall) ? FETCH : state;
`else
        state_n = (state == IDLE) ? FETCH :
                  redirect ? (trap ? HOLD : FETCH) :
                  ((state == FETCH) & imem_ack & stall) ? HOLD :
                  ((state == HOLD) & ~stall) ? FETCH : state;
`endif
    end

    always_comb begin
        imem_req  = (state == FETCH);
        imem_addr = pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_VECTOR;
            instr_out   <= 32'd0;
            instr_valid <= 1'b0;
            dec_pc4     <= 32'd0;
            flush       <= 1'b0;
            hold_buf    <= 32'd0;
        end else begin
            flush <= redirect;
            if (redirect) begin
                pc          <= target;
                instr_valid <= 1'b0;
            end else if (deliver) begin
                pc          <= pc4;
                instr_out   <= word;
                instr_valid <= 1'b1;
                dec_pc4     <= pc4;
            end else if (!stall) begin
                instr_valid <= 1'b0;
            end
            if ((state == FETCH) & imem_ack & stall) hold_buf <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed checks of fetch sequencing, redirects, stall hold and reset.
module tb_pc_fetch_ctrl;
    logic        clk = 1'b0, reset = 1'b1, stall = 1'b0;
    logic        imem_req, imem_ack = 1'b0, instr_valid, flush, misalign;
    logic [31:0] imem_addr, imem_rdata = 32'd0, instr_out, dec_pc4, jr_addr = 32'd0;
    logic        branch_en = 1'b0, branch_cond = 1'b0, jump_en = 1'b0, jr_en = 1'b0;
    logic [15:0] branch_imm = 16'd0;
    logic [25:0] jump_target = 26'd0;
    int chk = 0, err = 0;

    pc_fetch_ctrl #(.RESET_VECTOR(32'h400), .IMM_W(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_out(instr_out), .instr_valid(instr_valid),
        .dec_pc4(dec_pc4), .branch_en(branch_en), .branch_cond(branch_cond), .branch_imm(branch_imm),
        .jump_en(jump_en), .jump_target(jump_target), .jr_en(jr_en), .jr_addr(jr_addr),
        .flush(flush), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Leaves decode holding word w with dec_pc4 = pc4 and pc = pc4
    task automatic setup_dec(input logic [31:0] pc4, input logic [31:0] w);
        if (!instr_valid) begin
            imem_ack = 1'b1;
            step;
        end
        jr_en = 1'b1; jr_addr = pc4 - 32'd4; imem_ack = 1'b0;
        step;
        jr_en = 1'b0; imem_ack = 1'b1; imem_rdata = w;
        step;
        imem_ack = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; imem_ack = 1'b1;
        step; step;
        chk++; if (imem_req !== 1'b0) begin err++; $display("FAIL rst_req got %h exp 0", imem_req); end
        chk++; if (imem_addr !== 32'h400) begin err++; $display("FAIL rst_addr got %h exp 400", imem_addr); end
        chk++; if (instr_valid !== 1'b0 || instr_out !== 32'd0 || dec_pc4 !== 32'd0) begin err++; $display("FAIL rst_dec got v=%h i=%h p=%h exp 0", instr_valid, instr_out, dec_pc4); end
        chk++; if (flush !== 1'b0 || misalign !== 1'b0) begin err++; $display("FAIL rst_flags got f=%h m=%h exp 0", flush, misalign); end
        reset = 1'b0; imem_rdata = 32'hA0A0_0001;
        step;
        chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin err++; $display("FAIL seq0 got r=%h a=%h exp 1/400", imem_req, imem_addr); end
        chk++; if (instr_valid !== 1'b0) begin err++; $display("FAIL seq0_valid got %h exp 0", instr_valid); end
        step;
        chk++; if (imem_addr !== 32'h404) begin err++; $display("FAIL seq1_addr got %h exp 404", imem_addr); end
        chk++; if (instr_valid !== 1'b1 || dec_pc4 !== 32'h404 || instr_out !== 32'hA0A0_0001) begin err++; $display("FAIL seq1_dec got v=%h p=%h i=%h exp 1/404/a0a00001", instr_valid, dec_pc4, instr_out); end
        imem_rdata = 32'hA0A0_0002;
        step;
        chk++; if (imem_addr !== 32'h408 || dec_pc4 !== 32'h408 || instr_out !== 32'hA0A0_0002) begin err++; $display("FAIL seq2 got a=%h p=%h i=%h exp 408/408/a0a00002", imem_addr, dec_pc4, instr_out); end
        imem_ack = 1'b0;
    endtask

    task automatic test_branch;
        setup_dec(32'h1000, 32'hB0);
        chk++; if (dec_pc4 !== 32'h1000 || instr_valid !== 1'b1) begin err++; $display("FAIL br_setup got p=%h v=%h exp 1000/1", dec_pc4, instr_valid); end
        branch_en = 1'b1; branch_cond = 1'b1; branch_imm = 16'hFFFC; imem_ack = 1'b1;
        step;
        branch_en = 1'b0; imem_ack = 1'b0;
        chk++; if (flush !== 1'b1 || imem_addr !== 32'h0FF0 || instr_valid !== 1'b0) begin err++; $display("FAIL br_neg got f=%h a=%h v=%h exp 1/ff0/0", flush, imem_addr, instr_valid); end
        step;
        chk++; if (flush !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0FF0) begin err++; $display("FAIL br_pulse got f=%h r=%h a=%h exp 0/1/ff0", flush, imem_req, imem_addr); end
        setup_dec(32'h1000, 32'hB1);
        branch_en = 1'b1; branch_imm = 16'h0003;
        step;
        branch_en = 1'b0;
        chk++; if (flush !== 1'b1 || imem_addr !== 32'h100C) begin err++; $display("FAIL br_pos got f=%h a=%h exp 1/100c", flush, imem_addr); end
        setup_dec(32'h1000, 32'hB2);
        branch_en = 1'b1; branch_cond = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hB3;
        step;
        branch_en = 1'b0; imem_ack = 1'b0;
        chk++; if (flush !== 1'b0 || imem_addr !== 32'h1004 || dec_pc4 !== 32'h1004 || instr_out !== 32'hB3) begin err++; $display("FAIL br_nt got f=%h a=%h p=%h i=%h exp 0/1004/1004/b3", flush, imem_addr, dec_pc4, instr_out); end
    endtask

    task automatic test_stall;
        setup_dec(32'h3000, 32'hC0);
        stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hC1;
        step;
        imem_ack = 1'b0; imem_rdata = 32'hDEAD;
        for (int i = 0; i < 3; i++) begin
            chk++; if (imem_req !== 1'b0 || imem_addr !== 32'h3000 || instr_out !== 32'hC0 || instr_valid !== 1'b1 || dec_pc4 !== 32'h3000) begin err++; $display("FAIL hold%0d got r=%h a=%h i=%h v=%h p=%h exp 0/3000/c0/1/3000", i, imem_req, imem_addr, instr_out, instr_valid, dec_pc4); end
            if (i < 2) step;
        end
        stall = 1'b0;
        step;
        chk++; if (instr_out !== 32'hC1 || instr_valid !== 1'b1 || dec_pc4 !== 32'h3004 || imem_addr !== 32'h3004 || imem_req !== 1'b1) begin err++; $display("FAIL unhold got i=%h v=%h p=%h a=%h r=%h exp c1/1/3004/3004/1", instr_out, instr_valid, dec_pc4, imem_addr, imem_req); end
        step;
        chk++; if (instr_valid !== 1'b0 || imem_addr !== 32'h3004) begin err++; $display("FAIL once got v=%h a=%h exp 0/3004", instr_valid, imem_addr); end
    endtask

    task automatic test_jr_priority;
        setup_dec(32'h5000, 32'hD0);
        jr_en = 1'b1; jump_en = 1'b1; jr_addr = 32'h2000; jump_target = 26'h10; imem_ack = 1'b1; imem_rdata = 32'hD1;
        step;
        jr_en = 1'b0; jump_en = 1'b0; imem_ack = 1'b0;
        chk++; if (imem_addr !== 32'h2000 || instr_valid !== 1'b0 || flush !== 1'b1 || instr_out !== 32'hD0) begin err++; $display("FAIL jr_prio got a=%h v=%h f=%h i=%h exp 2000/0/1/d0", imem_addr, instr_valid, flush, instr_out); end
        setup_dec(32'h5000, 32'hD2);
        jump_en = 1'b1; jump_target = 26'h10;
        step;
        jump_en = 1'b0;
        chk++; if (imem_addr !== 32'h0000_0040 || flush !== 1'b1) begin err++; $display("FAIL jump got a=%h f=%h exp 40/1", imem_addr, flush); end
    endtask

    task automatic test_misalign;
        setup_dec(32'h6000, 32'hE0);
        jr_en = 1'b1; jr_addr = 32'h2002;
        step;
        jr_en = 1'b0; imem_ack = 1'b1;
`ifdef MISALIGN_TRAP_EN
        chk++; if (misalign !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h2002) begin err++; $display("FAIL trap got m=%h r=%h a=%h exp 1/0/2002", misalign, imem_req, imem_addr); end
        step; step;
        chk++; if (misalign !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin err++; $display("FAIL trap_stay got m=%h r=%h v=%h exp 1/0/0", misalign, imem_req, instr_valid); end
        reset = 1'b1;
        step;
        reset = 1'b0;
        chk++; if (misalign !== 1'b0 || imem_addr !== 32'h400) begin err++; $display("FAIL trap_rst got m=%h a=%h exp 0/400", misalign, imem_addr); end
        step;
`else
        chk++; if (misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h2000) begin err++; $display("FAIL jr_align got m=%h r=%h a=%h exp 0/1/2000", misalign, imem_req, imem_addr); end
`endif
        imem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_fetch;
        setup_dec(32'h7000, 32'hF0);
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hF1; jr_en = 1'b1; jr_addr = 32'h8000;
        step;
        jr_en = 1'b0;
        chk++; if (imem_req !== 1'b0 || imem_addr !== 32'h400 || instr_valid !== 1'b0 || instr_out !== 32'd0 || dec_pc4 !== 32'd0 || flush !== 1'b0 || misalign !== 1'b0) begin err++; $display("FAIL rst_mid got r=%h a=%h v=%h i=%h p=%h f=%h m=%h exp 0/400/0/0/0/0/0", imem_req, imem_addr, instr_valid, instr_out, dec_pc4, flush, misalign); end
        reset = 1'b0;
        step;
        chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin err++; $display("FAIL rst_resume got r=%h a=%h exp 1/400", imem_req, imem_addr); end
        imem_ack = 1'b0;
    endtask

    initial begin
        test_reset;
        test_branch;
        test_stall;
        test_jr_priority;
        test_misalign;
        test_reset_mid_fetch;
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter sequencer and instruction-fetch controller for the single-issue core.
- Owns the PC register and drives the instruction-memory request/acknowledge handshake.
- Delivers fetched words to decode.
- Computes branch targets from the sign-extended 16-bit offset, plus jump and jump-register targets.
- Flushes the in-flight fetch on every redirect.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
IMM_W, 16, branch offset width; sign-extended to 32 bits, then shifted left by 2

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
stall  in  1  decode stall; freezes the delivered instruction and the PC
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, equal to the PC
imem_ack  in  1  imem_rdata is valid this cycle
imem_rdata  in  32  fetched word
instr_out  out  32  instruction delivered to decode
instr_valid  out  1  instr_out is valid
dec_pc4  out  32  address of the delivered instruction + 4
branch_en  in  1  decode holds a branch
branch_cond  in  1  branch comparison result (1 = taken)
branch_imm  in  IMM_W  branch offset in words
jump_en  in  1  J-type jump
jump_target  in  26  J-type index field
jr_en  in  1  register jump
jr_addr  in  32  register jump target
flush  out  1  one-cycle pulse on a taken redirect
misalign  out  1  jr target misaligned (see Optional Feature)

Behaviour:
- Reset values: pc=RESET_VECTOR, state=IDLE, imem_req=0, instr_valid=0, instr_out=0, dec_pc4=0, flush=0, misalign=0. Reset overrides every other input in the same cycle.
- States: IDLE, FETCH, HOLD (plus TRAP when MISALIGN_TRAP_EN is defined).
- IDLE -> FETCH unconditionally on the next cycle.
- FETCH:
  - imem_req=1, imem_addr=pc. Request and address stay stable until ack.
  - Ack with stall=0: register instr_out<=imem_rdata, instr_valid<=1, dec_pc4<=pc+4, pc<=pc+4. Stay in FETCH. Back-to-back acks give one instruction per cycle.
  - Ack with stall=1: go to HOLD with the word buffered. pc does not advance.
  - No ack: instr_valid<=0.
- HOLD:
  - imem_req=0. instr_out and instr_valid stay as they were.
  - When stall falls: deliver the buffered word (instr_valid=1, dec_pc4 updated), pc<=pc+4, return to FETCH.
- While stall=1, instr_out, instr_valid and dec_pc4 are frozen and all redirect inputs are ignored.
- Redirect inputs are evaluated only when instr_valid=1 and stall=0. Priority is jr_en > jump_en > (branch_en & branch_cond).
  - Branch target = dec_pc4 + ({{(32-IMM_W){branch_imm[IMM_W-1]}}, branch_imm} << 2). 32-bit arithmetic; wrap-around is modulo 2^32 and is not flagged.
  - Jump target = {dec_pc4[31:28], jump_target, 2'b00}.
  - JR target = jr_addr.
- On a redirect:
  - pc<=target and flush=1 for exactly one cycle.
  - instr_valid<=0 next cycle. Any ack arriving in the redirect cycle is discarded.
  - Next state is FETCH with the new pc.
  - A not-taken branch (branch_en=1, branch_cond=0) produces no flush and no PC change.
- Simultaneous ack and redirect: the redirect wins and the word is dropped.
- Fetch-to-delivery latency is 1 cycle after ack. Redirect-to-new-request latency is 1 cycle.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - A jr redirect with jr_addr[1:0]!=0 sets misalign=1 (sticky) and enters TRAP.
  - TRAP holds imem_req=0 and instr_valid=0; only reset exits it. pc is loaded with jr_addr unmodified.
- Not defined:
  - No TRAP state.
  - The jr target is loaded as {jr_addr[31:2], 2'b00}.
  - misalign is tied to 0.

Test Plan:
- Reset with RESET_VECTOR=0x400, ack every cycle: imem_addr=0x400, 0x404, 0x408 on consecutive cycles; first instr_valid=1 on the cycle after the first ack, with dec_pc4=0x404.
- Branch taken: dec_pc4=0x1000, branch_imm=16'hFFFC -> flush pulse, next imem_addr=0x0FF0. Same with imm=16'h0003 -> 0x100C. Same with branch_cond=0 -> no flush, sequential address.
- Ack arrives with stall=1 held 3 cycles -> HOLD, instr_out stable, imem_req=0, pc unchanged; stall falls -> word delivered once, next fetch is pc+4.
- jr_en and jump_en asserted together, jr_addr=0x2000, jump_target=26'h10 -> jr wins, imem_addr=0x2000; ack in the same cycle is discarded (instr_valid=0).
- jr_addr=0x2002: with MISALIGN_TRAP_EN defined -> misalign=1, imem_req=0 until reset. Without it -> fetch from 0x2000, misalign=0.
- Reset asserted mid-FETCH while ack=1 -> next cycle all outputs at reset values, imem_req=0, pc=RESET_VECTOR.
